// File: rtl/set_mode_ctrl.sv
// Front-panel mode/cursor controller: MODE/NEXT buttons to S, CW, CW1, BLINK.
// Optional idle auto-exit to run mode: define SET_MODE_CTRL_AUTO_EXIT_EN.
module set_mode_ctrl #(
  parameter int BLINK_DIV = 250,
  parameter int TIMEOUT   = 15000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TICK,
  input  logic       BTN_MODE,
  input  logic       BTN_NEXT,
  output logic [1:0] S,
  output logic [1:0] CW,
  output logic [1:0] CW1,
  output logic       BLINK
);

  typedef enum logic [1:0] {
    RUN  = 2'b00,
    VIEW = 2'b01,
    ASET = 2'b10,
    TSET = 2'b11
  } mode_t;

  localparam int CNT_W = $clog2(BLINK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  mode_t            mode;
  mode_t            mode_nxt;
  logic             mode_h;
  logic             next_h;
  logic             mode_rst_held;
  logic             next_rst_held;
  logic             mode_press;
  logic             next_press;
  logic             any_press;
  logic             editing;
  logic             expire;
  logic [1:0]       cw_nxt;
  logic [1:0]       cw1_nxt;
  logic [CNT_W-1:0] cnt;

  // A button held through reset release must not count as a fresh press.
  always_comb begin
    mode_press = BTN_MODE & ~mode_h & ~mode_rst_held;
    next_press = BTN_NEXT & ~next_h & ~next_rst_held;
    any_press  = mode_press | next_press;
    editing    = (mode == ASET) | (mode == TSET);
  end

  always_comb begin
    mode_nxt = mode;
    cw_nxt   = CW;
    cw1_nxt  = CW1;
    if (mode_press) begin
      unique case (mode)
        RUN:  mode_nxt = VIEW;
        VIEW: begin
          mode_nxt = ASET;
          cw1_nxt  = 2'b00;
        end
        ASET: begin
          mode_nxt = TSET;
          cw_nxt   = 2'b00;
        end
        TSET: mode_nxt = RUN;
      endcase
    end else if (next_press) begin
      unique case (mode)
        ASET: cw1_nxt = (CW1 == 2'b10) ? 2'b00 : CW1 + 2'b01;
        TSET: cw_nxt  = CW + 2'b01;
        default: ;
      endcase
    end
  end

`ifdef SET_MODE_CTRL_AUTO_EXIT_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  logic [IDLE_W-1:0] idle;

  // A press in the expiring cycle keeps the user in the edit mode.
  assign expire = TICK & (mode != RUN) & (idle == IDLE_LAST) & ~any_press;

  always_ff @(posedge CLK) begin
    if (RST) begin
      idle <= '0;
    end else if (any_press | expire | (mode == RUN)) begin
      idle <= '0;
    end else if (TICK) begin
      idle <= idle + IDLE_W'(1);
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign expire = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      mode          <= RUN;
      CW            <= 2'b00;
      CW1           <= 2'b00;
      BLINK         <= 1'b1;
      cnt           <= '0;
      mode_h        <= 1'b0;
      next_h        <= 1'b0;
      mode_rst_held <= BTN_MODE;
      next_rst_held <= BTN_NEXT;
    end else begin
      mode_h        <= BTN_MODE;
      next_h        <= BTN_NEXT;
      mode_rst_held <= 1'b0;
      next_rst_held <= 1'b0;
      CW            <= cw_nxt;
      CW1           <= cw1_nxt;
      if (any_press) begin
        mode  <= mode_nxt;
        BLINK <= 1'b1;
        cnt   <= '0;
      end else if (expire) begin
        mode  <= RUN;
        BLINK <= 1'b1;
        cnt   <= '0;
      end else if (!editing) begin
        BLINK <= 1'b1;
        cnt   <= '0;
      end else if (TICK) begin
        if (cnt == CNT_LAST) begin
          cnt   <= '0;
          BLINK <= ~BLINK;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  assign S = mode;

endmodule

// File: doc/set_mode_ctrl.md
Name: set_mode_ctrl

Overview:
Front-panel mode and cursor controller for the alarm clock.
- Turns the MODE and NEXT push-buttons into the display mode code S, the time-set field cursor CW, the alarm-set field cursor CW1, and the BLINK phase.
- Feeds the digit-blanking stage directly downstream, which combines S/CW/CW1/BLINK into per-digit enables.
- Sits between the debounced button inputs and the display-enable logic, clocked by the system clock and timed by the 1 kHz TICK strobe.

Parameters:
BLINK_DIV, 250, TICK strobes per BLINK half-period (2 Hz blink at a 1 kHz TICK); must be >= 2.
TIMEOUT, 15000, TICK strobes of button inactivity before auto-exit to run mode (AUTO_EXIT_EN only).

Ports:
CLK  input  1  system clock, all logic on rising edge.
RST  input  1  reset, synchronous and active-high.
TICK  input  1  one-CLK-wide 1 kHz timebase strobe.
BTN_MODE  input  1  debounced, CLK-synchronous level, high while pressed.
BTN_NEXT  input  1  debounced, CLK-synchronous level, high while pressed.
S  output  2  mode: 00 run, 01 alarm view, 10 alarm set, 11 time set.
CW  output  2  time-set field cursor, 00..11.
CW1  output  2  alarm-set field cursor, 00..10.
BLINK  output  1  blink phase: 1 = selected field visible, 0 = blanked.

Behaviour:
- Reset: synchronous and active-high. RST high at a clock edge forces S=00, CW=00, CW1=00, BLINK=1, blink counter=0, idle counter=0, button history=0. RST overrides every other input in the same cycle, including mid-edit.
- Edge detect: one history register per button. A press is a cycle where BTN is 1 and its history bit is 0. A held button produces exactly one press. A button already high when RST drops is not a press.
- Latency: a press sampled in cycle n updates the registered outputs at the edge ending cycle n, so the new value is visible in cycle n+1.
- Mode FSM, advanced by a MODE press: 00 -> 01 -> 10 -> 11 -> 00.
  - Entry to 10 loads CW1=00.
  - Entry to 11 loads CW=00.
  - CW and CW1 otherwise hold their values in every mode.
- NEXT press:
  - In mode 10: CW1 steps 00 -> 01 -> 10 -> 00. Value 11 is never produced.
  - In mode 11: CW steps 00 -> 01 -> 10 -> 11 -> 00.
  - In modes 00 and 01: ignored.
- Simultaneous MODE and NEXT presses in one cycle: MODE is acted on, NEXT is discarded.
- BLINK generation:
  - In modes 00/01: BLINK is held at 1 and the blink counter at 0.
  - In modes 10/11: each TICK increments the blink counter. A TICK with counter == BLINK_DIV-1 clears the counter and toggles BLINK.
  - Counter width is clog2(BLINK_DIV).
- Blink restart: any MODE or NEXT press sets BLINK=1 and clears the counter that cycle. This takes priority over a coincident TICK, so a newly selected field always shows for a full half-period.
- Invariant: no output ever takes a value outside its stated range.

Optional Feature:
Macro: SET_MODE_CTRL_AUTO_EXIT_EN.
- Defined:
  - An idle counter sized clog2(TIMEOUT+1) counts TICKs while S != 00.
  - It clears on any press, on reset, and whenever S == 00.
  - The TICK that brings it to TIMEOUT forces S=00, BLINK=1 and clears both counters at that edge. CW and CW1 are unchanged.
  - A press in the same cycle as that TICK wins; there is no exit.
- Undefined: no idle counter. S changes only on a MODE press or RST.

Test Plan:
1. RST pulse during mode 11 with CW=10 -> next cycle S=00, CW=00, CW1=00, BLINK=1. Holding BTN_MODE high across the RST release gives no mode change.
2. Four single-cycle MODE presses -> S goes 01, 10, 11, 00, each one cycle after its press. Holding MODE for 10 cycles advances S only once.
3. In mode 10, four NEXT presses -> CW1 goes 01, 10, 00, 01. In mode 11, five NEXT presses -> CW goes 01, 10, 11, 00, 01. NEXT in mode 00 leaves CW/CW1 unchanged.
4. BLINK_DIV=4, mode 11, TICK every 3 cycles -> BLINK toggles on every 4th TICK (1,0,1,...). A NEXT press coincident with a TICK while BLINK=0 gives BLINK=1 and the counter restarts from 0.
5. MODE and NEXT pressed in the same cycle in mode 10 -> S=11 and CW=00, with CW1 unchanged.
6. With SET_MODE_CTRL_AUTO_EXIT_EN and TIMEOUT=20, enter mode 10 and give no presses -> S=00 at the edge of the 20th TICK. Repeating with a NEXT press at TICK 19 -> still in mode 10 at TICK 20, exit after 20 further TICKs. Without the macro, S stays 10 indefinitely.
